// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS core front end: reset defaults, bubble word,
// PC step and the fetch FSM encoding.
package mips_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] PC_INCR           = 32'd4;

    typedef logic [1:0] fetch_state_t;

    localparam fetch_state_t ST_IDLE = 2'd0;
    localparam fetch_state_t ST_REQ  = 2'd1;
    localparam fetch_state_t ST_HOLD = 2'd2;

endpackage

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches over a req/ready handshake and
// writes {PC+4, instruction} into IF/ID, honouring stall and branch/jump redirects.
module if_fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] PC_out,
    output logic [31:0] instruction_out,
    output logic        fetch_valid
);

    // Handshake: imem_req is valid, imem_ready completes it; a transfer happens on
    // any cycle with imem_req & imem_ready, and imem_addr is frozen while req waits.
    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  req_addr_q, req_addr_d;
    logic [31:0]  pc_out_q, pc_out_d;
    logic [31:0]  instr_q, instr_d;
    logic         valid_q, valid_d;
    logic         drop_pending_q, drop_pending_d;
    logic         skid_valid_q, skid_valid_d;
    logic [31:0]  skid_pc_q, skid_pc_d;
    logic [31:0]  skid_instr_q, skid_instr_d;

    logic         redirect;
    logic [31:0]  target;
    logic         complete;
    logic [31:0]  next_addr;

    assign redirect  = branch_taken | jump;
    assign target    = (branch_taken ? branch_target : jump_target) & 32'hFFFF_FFFC;
    assign imem_req  = (state_q == ST_REQ);
    assign imem_addr = req_addr_q;
    assign complete  = imem_req & imem_ready;
    assign next_addr = req_addr_q + PC_INCR;

    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        req_addr_d     = req_addr_q;
        pc_out_d       = pc_out_q;
        instr_d        = instr_q;
        valid_d        = valid_q;
        drop_pending_d = drop_pending_q;
        skid_valid_d   = skid_valid_q;
        skid_pc_d      = skid_pc_q;
        skid_instr_d   = skid_instr_q;

        // A redirect always flushes the IF/ID slot, even under stall.
        if (redirect) begin
            pc_d    = target;
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                state_d    = ST_REQ;
                req_addr_d = redirect ? target : pc_q;
            end
            ST_REQ: begin
                if (complete && drop_pending_q) begin
                    drop_pending_d = 1'b0;
                    req_addr_d     = redirect ? target : pc_q;
                    if (!redirect && !stall) begin
                        instr_d = NOP_INSTR;
                        valid_d = 1'b0;
                    end
                end else if (complete && redirect) begin
                    req_addr_d = target;
                end else if (complete && stall) begin
                    skid_valid_d = 1'b1;
                    skid_pc_d    = next_addr;
                    skid_instr_d = imem_rdata;
                    state_d      = ST_HOLD;
                end else if (complete) begin
                    pc_out_d   = next_addr;
                    instr_d    = imem_rdata;
                    valid_d    = 1'b1;
                    pc_d       = next_addr;
                    req_addr_d = next_addr;
                end else if (redirect) begin
                    // Outstanding request must finish at its original address.
                    drop_pending_d = 1'b1;
                end else if (!stall) begin
                    instr_d = NOP_INSTR;
                    valid_d = 1'b0;
                end
            end
            ST_HOLD: begin
                if (redirect) begin
                    req_addr_d   = target;
                    skid_valid_d = 1'b0;
                    state_d      = ST_REQ;
                end else if (!stall && skid_valid_q) begin
                    pc_out_d     = skid_pc_q;
                    instr_d      = skid_instr_q;
                    valid_d      = 1'b1;
                    pc_d         = skid_pc_q;
                    req_addr_d   = skid_pc_q;
                    skid_valid_d = 1'b0;
                    state_d      = ST_REQ;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            pc_q           <= RESET_PC;
            req_addr_q     <= RESET_PC;
            pc_out_q       <= 32'h0000_0000;
            instr_q        <= NOP_INSTR;
            valid_q        <= 1'b0;
            drop_pending_q <= 1'b0;
            skid_valid_q   <= 1'b0;
            skid_pc_q      <= 32'h0000_0000;
            skid_instr_q   <= NOP_INSTR;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            req_addr_q     <= req_addr_d;
            pc_out_q       <= pc_out_d;
            instr_q        <= instr_d;
            valid_q        <= valid_d;
            drop_pending_q <= drop_pending_d;
            skid_valid_q   <= skid_valid_d;
            skid_pc_q      <= skid_pc_d;
            skid_instr_q   <= skid_instr_d;
        end
    end

    assign PC_out          = pc_out_q;
    assign instruction_out = instr_q;
    assign fetch_valid     = valid_q;

endmodule
